// File: rtl/ov5642_capture_ctrl.sv
// ov5642_capture_ctrl
// Frame capture controller between the OV5642 byte aligner and the frame
// buffer writer. After an arm request it waits for a frame boundary, then
// forwards whole frames only: SOF is tagged on m_tuser, every frame is closed
// with m_tlast, and frames are held to exactly FRAME_PIXELS beats (short
// frames are flagged, long frames are truncated and their tail dropped).
// The stream has no backpressure; the sink must take every beat.
//
// Ports
//   pclk, rst             pixel clock (rising edge), async active-high reset
//   arm                   pulse, start capture (IDLE only)
//   continuous            level, sampled at frame end: keep capturing frames
//   abort                 pulse, stop at the next frame boundary
//   s_tdata/tvalid/tlast  RGB565 input stream, tlast marks end of frame
//   m_tdata/tvalid/tlast  forwarded stream, 1-cycle latency
//   m_tuser               first beat of a forwarded frame
//   busy                  controller not idle
//   frame_done            pulse with the m_tlast beat
//   err_short, err_long   pulses with the m_tlast beat of a bad-size frame
//   pixel_count           beats forwarded in the current frame
//   frame_count           completed frames since reset (wraps)
module ov5642_capture_ctrl #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              arm,
    input  logic              continuous,
    input  logic              abort,
    input  logic [15:0]       s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic [15:0]       m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              busy,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  pixel_count,
    output logic [FCNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        DROP
    } state_t;

    state_t            state;
    logic              stop_req;
    logic              last_beat;
    logic [CNT_W-1:0]  cnt_next;
    logic              at_limit;
    logic              keep_going;

    assign last_beat  = s_tvalid & s_tlast;
    assign cnt_next   = pixel_count + CNT_W'(1);
    // The beat being forwarded is number FRAME_PIXELS of the frame.
    assign at_limit   = (cnt_next == CNT_W'(FRAME_PIXELS));
    // An abort arriving on the frame-end cycle itself also stops capture.
    assign keep_going = continuous & ~stop_req & ~abort;

    assign busy = (state != IDLE);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stop_req    <= 1'b0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tuser     <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            pixel_count <= '0;
            frame_count <= '0;
        end else begin
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tuser    <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;

            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    if (arm && !abort) begin
                        state <= SYNC;
                    end
                end

                // Armed mid-frame possibly: wait for a frame end before capturing.
                SYNC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (last_beat) begin
                        state       <= CAPTURE;
                        pixel_count <= '0;
                    end
                end

                CAPTURE: begin
                    if (abort) begin
                        stop_req <= 1'b1;
                    end
                    if (s_tvalid) begin
                        m_tvalid    <= 1'b1;
                        m_tdata     <= s_tdata;
                        m_tuser     <= (pixel_count == '0);
                        pixel_count <= cnt_next;
                        if (s_tlast || at_limit) begin
                            m_tlast     <= 1'b1;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FCNT_W'(1);
                            err_short   <= s_tlast & ~at_limit;
                            err_long    <= ~s_tlast & at_limit;
                            if (!s_tlast) begin
                                // Truncated: the rest of the source frame is
                                // dropped; the continue decision waits for its tlast.
                                state <= DROP;
                            end else if (keep_going) begin
                                pixel_count <= '0;
                            end else begin
                                state    <= IDLE;
                                stop_req <= 1'b0;
                            end
                        end
                    end
                end

                DROP: begin
                    if (abort) begin
                        stop_req <= 1'b1;
                    end
                    if (last_beat) begin
                        if (keep_going) begin
                            state       <= CAPTURE;
                            pixel_count <= '0;
                        end else begin
                            state    <= IDLE;
                            stop_req <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5642_capture_ctrl.sv
module tb_ov5642_capture_ctrl;

    localparam int unsigned FP = 16;
    localparam int unsigned CW = 20;
    localparam int unsigned FW = 16;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [15:0]   m_tdata;
    logic          m_tvalid, m_tlast, m_tuser, busy;
    logic          frame_done, err_short, err_long;
    logic [CW-1:0] pixel_count;
    logic [FW-1:0] frame_count;

    ov5642_capture_ctrl #(
        .FRAME_PIXELS(FP),
        .CNT_W(CW),
        .FCNT_W(FW)
    ) dut (
        .pclk(pclk), .rst(rst), .arm(arm), .continuous(continuous), .abort(abort),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .busy(busy), .frame_done(frame_done), .err_short(err_short), .err_long(err_long),
        .pixel_count(pixel_count), .frame_count(frame_count)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
        logic        done;
        logic        es;
        logic        el;
    } beat_t;

    typedef struct packed {
        logic          arm, abort, cont, tv, tl;
        logic [15:0]   d;
        logic          e_v, e_u, e_l, e_es, e_busy;
        logic [15:0]   e_d;
        logic [CW-1:0] e_pc;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } in_t;

    beat_t       outq[$];
    logic [15:0] last_data = '0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Output monitor: collects forwarded beats, and checks quiet cycles.
    always @(negedge pclk) begin
        if (rst) begin
            last_data = '0;
        end else if (m_tvalid) begin
            beat_t b;
            b.data = m_tdata; b.user = m_tuser; b.last = m_tlast;
            b.done = frame_done; b.es = err_short; b.el = err_long;
            outq.push_back(b);
            last_data = m_tdata;
        end else begin
            chk("idle_flags", {m_tlast, m_tuser, frame_done, err_short, err_long}, '0);
            chk("tdata_hold", m_tdata, last_data);
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        tick(); tick();
        rst = 1'b0;
        outq.delete();
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send_frame(input int unsigned len, input logic [7:0] id);
        for (int unsigned i = 0; i < len; i++) begin
            beat({id, 8'(i)}, i == len - 1);
        end
    endtask

    function automatic int count_user();
        int n = 0;
        foreach (outq[i]) if (outq[i].user) n++;
        return n;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (outq[i]) if (outq[i].last) n++;
        return n;
    endfunction

    vec_t  tbl[13];
    in_t   stim[$];
    beat_t expq[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        //          arm ab cn tv tl d          v  u  l  es bsy e_d       pc
        tbl[0]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 16'hAAAA, 0, 0, 0, 0, 1, 16'h0000, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 16'hBBBB, 0, 0, 0, 0, 1, 16'h0000, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 16'h0101, 1, 1, 0, 0, 1, 16'h0101, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 1, 16'h0101, 1};
        tbl[8]  = '{0, 0, 0, 1, 0, 16'h0202, 1, 0, 0, 0, 1, 16'h0202, 2};
        tbl[9]  = '{0, 0, 0, 1, 1, 16'h0303, 1, 0, 1, 1, 0, 16'h0303, 3};
        tbl[10] = '{0, 0, 0, 1, 1, 16'h0404, 0, 0, 0, 0, 0, 16'h0303, 3};
        tbl[11] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0303, 3};
        tbl[12] = '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0303, 3};

        do_reset();
        chk("reset_outputs", {m_tdata, m_tvalid, m_tlast, m_tuser, busy, frame_done,
                              err_short, err_long, pixel_count, frame_count}, '0);

        // Table-driven cycle vectors
        for (int i = 0; i < 13; i++) begin
            arm = tbl[i].arm; abort = tbl[i].abort; continuous = tbl[i].cont;
            s_tvalid = tbl[i].tv; s_tlast = tbl[i].tl; s_tdata = tbl[i].d;
            tick();
            chk($sformatf("vec%0d_flags", i),
                {m_tvalid, m_tuser, m_tlast, frame_done, err_short, err_long, busy},
                {tbl[i].e_v, tbl[i].e_u, tbl[i].e_l, tbl[i].e_l, tbl[i].e_es, 1'b0, tbl[i].e_busy});
            chk($sformatf("vec%0d_data", i), m_tdata, tbl[i].e_d);
            chk($sformatf("vec%0d_pcount", i), pixel_count, tbl[i].e_pc);
        end
        arm = 1'b0; abort = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;

        // Arm mid-frame, single shot
        do_reset();
        pulse_arm();
        send_frame(5, 8'hE0);
        send_frame(FP, 8'h01);
        tick(); tick();
        chk("single_beats", outq.size(), FP);
        chk("single_sof", count_user(), 1);
        chk("single_last", count_last(), 1);
        if (outq.size() == FP) begin
            chk("single_first", outq[0], {16'h0100, 5'b10000});
            chk("single_end", outq[FP-1], {16'h010F, 5'b01100});
        end
        chk("single_fcount", frame_count, 1);
        chk("single_busy", busy, 0);
        chk("single_pcount", pixel_count, FP);

        // Continuous, three frames back to back
        do_reset();
        continuous = 1'b1;
        pulse_arm();
        beat(16'h0, 1'b1);
        send_frame(FP, 8'h01);
        send_frame(FP, 8'h02);
        send_frame(FP, 8'h03);
        tick();
        chk("cont_beats", outq.size(), 3 * FP);
        chk("cont_sof", count_user(), 3);
        chk("cont_last", count_last(), 3);
        chk("cont_fcount", frame_count, 3);
        chk("cont_busy", busy, 1);
        chk("cont_pcount", pixel_count, 0);

        // Long frame truncation then next frame
        do_reset();
        continuous = 1'b1;
        pulse_arm();
        beat(16'h0, 1'b1);
        send_frame(20, 8'h01);
        send_frame(FP, 8'h02);
        tick();
        chk("long_beats", outq.size(), 2 * FP);
        if (outq.size() == 2 * FP) begin
            chk("long_trunc", outq[FP-1], {16'h010F, 5'b01101});
            chk("long_next_sof", outq[FP], {16'h0200, 5'b10000});
        end
        chk("long_fcount", frame_count, 2);

        // Abort during capture completes the frame, then idles
        do_reset();
        continuous = 1'b1;
        pulse_arm();
        beat(16'h0, 1'b1);
        for (int unsigned i = 0; i < FP; i++) begin
            abort = (i == 7);
            beat({8'h01, 8'(i)}, i == FP - 1);
        end
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        send_frame(FP, 8'h02);
        tick();
        chk("abort_beats", outq.size(), FP);
        chk("abort_last", count_last(), 1);
        chk("abort_fcount", frame_count, 1);
        pulse_arm();
        chk("sync_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("sync_abort", busy, 0);

        // Reset mid-frame
        do_reset();
        pulse_arm();
        beat(16'h0, 1'b1);
        for (int unsigned i = 0; i < 6; i++) beat({8'h01, 8'(i)}, 1'b0);
        s_tvalid = 1'b1; s_tdata = 16'h0106; s_tlast = 1'b0;
        @(posedge pclk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {m_tdata, m_tvalid, m_tlast, m_tuser, busy, frame_done,
                                err_short, err_long, pixel_count, frame_count}, '0);
        s_tvalid = 1'b0;
        @(posedge pclk);
        #1 rst = 1'b0;
        outq.delete();
        for (int unsigned i = 7; i < FP; i++) beat({8'h01, 8'(i)}, i == FP - 1);
        tick();
        chk("rst_mid_quiet", outq.size(), 0);
        pulse_arm();
        chk("rst_rearm_busy", busy, 1);
        beat(16'h1234, 1'b0);
        chk("rst_rearm_sync", m_tvalid, 0);

        // Randomized frames against a frame-level reference
        for (int t = 0; t < 25; t++) begin
            int unsigned nf, len, len0, n;
            logic cont;
            do_reset();
            cont = 1'($urandom_range(0, 1));
            continuous = cont;
            stim.delete();
            expq.delete();
            len0 = 0;
            n = $urandom_range(1, 6);
            for (int unsigned i = 0; i < n; i++) stim.push_back({16'($urandom), i == n - 1});
            nf = $urandom_range(1, 4);
            for (int unsigned f = 0; f < nf; f++) begin
                case ($urandom_range(0, 2))
                    0: len = $urandom_range(1, FP - 1);
                    1: len = FP;
                    default: len = $urandom_range(FP + 1, FP + 8);
                endcase
                if (f == 0) len0 = len;
                n = (len < FP) ? len : FP;
                for (int unsigned i = 0; i < len; i++) begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    stim.push_back({d, i == len - 1});
                    if ((cont || f == 0) && i < n) begin
                        beat_t e;
                        e.data = d;
                        e.user = (i == 0);
                        e.last = (i == n - 1);
                        e.done = (i == n - 1);
                        e.es   = (i == n - 1) && (len < FP);
                        e.el   = (i == n - 1) && (len > FP);
                        expq.push_back(e);
                    end
                end
            end
            pulse_arm();
            foreach (stim[k]) begin
                if ($urandom_range(0, 3) == 0) tick();
                beat(stim[k].d, stim[k].l);
            end
            tick(); tick();
            chk($sformatf("rnd%0d_beats", t), outq.size(), expq.size());
            if (outq.size() == expq.size()) begin
                int bad = 0;
                foreach (expq[k]) if (outq[k] !== expq[k]) bad++;
                chk($sformatf("rnd%0d_stream_errs", t), bad, 0);
            end
            chk($sformatf("rnd%0d_fcount", t), frame_count, cont ? nf : 1);
            chk($sformatf("rnd%0d_pcount", t), pixel_count, cont ? 0 : ((len0 < FP) ? len0 : FP));
            chk($sformatf("rnd%0d_busy", t), busy, cont);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
